// File: rtl/discrete_audio_pkg.sv
// Shared helpers for the discrete-audio filter stages: sample width, saturation,
// RC coefficient math and the substep sequencer state encoding.
package discrete_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP_A,
    ST_STEP_B,
    ST_OUT
  } rc_state_e;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'h7fff;
    end else if (v < -18'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic signed [17:0] clamp18(input logic signed [39:0] v);
    if (v > 40'sd131071) begin
      return 18'h1ffff;
    end else if (v < -40'sd131072) begin
      return 18'h20000;
    end else begin
      return v[17:0];
    end
  endfunction

  // Coefficient RC/(RC+dt) in Q16; the low-pass stage uses 1 minus this value.
  function automatic logic [63:0] rc_alpha_16(input logic [63:0] r,
                                              input logic [63:0] c_35,
                                              input logic [63:0] fs,
                                              input logic [63:0] substeps);
    logic [63:0] dt_32;
    logic [63:0] rc_32;
    dt_32 = (64'd1 << 32) / (fs * substeps);
    rc_32 = (r * c_35) >> 3;
    return (rc_32 << 16) / (rc_32 + dt_32);
  endfunction

endpackage

// File: rtl/resistor_capacitor_high_pass_filter.sv
// RC high-pass stage: each strobed sample is interpolated into SUBSTEPS
// difference-equation steps sharing one multiplier between strobes.
module resistor_capacitor_high_pass_filter
  import discrete_audio_pkg::*;
#(
  parameter int CLOCK_RATE   = 50000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 47000,
  parameter int C_35_SHIFTED = 1615,
  parameter int SUBSTEPS     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                audio_clk_en,
  input  logic [SAMPLE_W-1:0] in,
  output logic [SAMPLE_W-1:0] out,
  output logic                busy,
  output logic                overrun
);

  localparam int          KSH      = $clog2(SUBSTEPS);
  localparam logic [6:0]  K_LAST   = 7'(SUBSTEPS);
  localparam logic [16:0] ALPHA_16 = 17'(rc_alpha_16(64'(R), 64'(C_35_SHIFTED),
                                                     64'(SAMPLE_RATE), 64'(SUBSTEPS)));

  if ((SUBSTEPS < 1) || (SUBSTEPS > 64) || ((SUBSTEPS & (SUBSTEPS - 1)) != 0)) begin : g_bad_substeps
    $error("SUBSTEPS must be a power of two in 1..64");
  end
  if ((2 * SUBSTEPS + 2) > (CLOCK_RATE / SAMPLE_RATE)) begin : g_bad_rate
    $error("not enough clock cycles per sample for SUBSTEPS");
  end

  rc_state_e          state_q;
  logic signed [15:0] x_prev_q, x_new_q, out_q;
  logic signed [16:0] x_sub_prev_q;
  logic signed [17:0] d_q, y_q;
  logic [6:0]         k_q;
  logic               busy_q, overrun_q;

  logic signed [16:0] diff, x_k;
  logic signed [24:0] ramp;
  logic signed [17:0] d_d, y_d;
  logic signed [18:0] acc;
  logic signed [36:0] prod;

  // x_k walks linearly from x_prev to x_new, landing exactly on x_new at k == SUBSTEPS.
  always_comb begin
    diff = 17'(x_new_q) - 17'(x_prev_q);
    ramp = (25'(diff) * $signed({18'd0, k_q})) >>> KSH;
    x_k  = 17'(x_prev_q) + 17'(ramp);
    d_d  = 18'(x_k) - 18'(x_sub_prev_q);
    acc  = 19'(y_q) + 19'(d_q);
    prod = 37'(acc) * $signed({20'd0, ALPHA_16});
    y_d  = clamp18(40'(prod >>> 16));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_prev_q     <= '0;
      x_new_q      <= '0;
      x_sub_prev_q <= '0;
      d_q          <= '0;
      y_q          <= '0;
      k_q          <= '0;
      out_q        <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (audio_clk_en) begin
            x_new_q <= in;
            k_q     <= 7'd1;
            busy_q  <= 1'b1;
            state_q <= ST_STEP_A;
          end
        end
        ST_STEP_A: begin
          if (audio_clk_en) begin
            // Abandon: resume the ramp from the last interpolated point reached.
            overrun_q <= 1'b1;
            x_prev_q  <= 16'(x_sub_prev_q);
            x_new_q   <= in;
            k_q       <= 7'd1;
          end else begin
            d_q          <= d_d;
            x_sub_prev_q <= x_k;
            state_q      <= ST_STEP_B;
          end
        end
        ST_STEP_B: begin
          if (audio_clk_en) begin
            overrun_q <= 1'b1;
            x_prev_q  <= 16'(x_sub_prev_q);
            x_new_q   <= in;
            k_q       <= 7'd1;
            state_q   <= ST_STEP_A;
          end else begin
            y_q <= y_d;
            if (k_q == K_LAST) begin
              state_q <= ST_OUT;
            end else begin
              k_q     <= k_q + 7'd1;
              state_q <= ST_STEP_A;
            end
          end
        end
        ST_OUT: begin
          out_q    <= sat16(y_q);
          x_prev_q <= x_new_q;
          if (audio_clk_en) begin
            x_new_q <= in;
            k_q     <= 7'd1;
            state_q <= ST_STEP_A;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// Bench for the RC high-pass stage against a substep-loop reference model.
module tb_resistor_capacitor_high_pass_filter;

  localparam int     S     = 8;
  localparam longint ALPHA = 65458;

  logic        clk = 1'b0;
  logic        reset;
  logic        audio_clk_en;
  logic [15:0] in_s;
  logic [15:0] out_s;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  longint      m_y, m_xprev, m_xsub;
  logic [15:0] m_out;

  resistor_capacitor_high_pass_filter dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .in           (in_s),
    .out          (out_s),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Runs the first n_a interpolation points and the first n_b filter updates of a sample.
  function automatic void model_steps(input longint xnew, input int n_a, input int n_b);
    longint xk, d;
    for (int k = 1; k <= S; k++) begin
      if (k <= n_a) begin
        xk     = m_xprev + fdiv((xnew - m_xprev) * k, S);
        d      = xk - m_xsub;
        m_xsub = xk;
        if (k <= n_b) m_y = clampv(fdiv(ALPHA * (m_y + d), 65536), -131072, 131071);
      end
    end
  endfunction

  function automatic logic [15:0] model_sample(input longint xnew);
    model_steps(xnew, S, S);
    m_xprev = xnew;
    m_out   = 16'(clampv(m_y, -32768, 32767));
    return m_out;
  endfunction

  // Sample interrupted by a strobe 'gap' edges after its own strobe.
  function automatic void model_abandon(input longint xnew, input int gap);
    model_steps(xnew, gap / 2, (gap - 1) / 2);
    m_xprev = m_xsub;
  endfunction

  function automatic void model_reset();
    m_y = 0; m_xprev = 0; m_xsub = 0; m_out = '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(input int v);
    audio_clk_en = 1'b1;
    in_s = 16'(v);
    @(posedge clk);
    #1;
    audio_clk_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] exp;
    int n;
    reset = 1'b1;
    tick();
    checks++; if (out_s !== 16'd0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out_s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    tick();
    model_reset();
    do_strobe(12000);
    exp = model_sample(12000);
    wait_idle(n);
    checks++; if (out_s !== exp) begin errors++; $display("FAIL reset_prime_out: got %0d expected %0d", $signed(out_s), $signed(exp)); end
    do_strobe(-7000);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    checks++; if (out_s !== 16'd0) begin errors++; $display("FAIL reset_mid_out: got %0h expected 0", out_s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_mid_overrun: got %b expected 0", overrun); end
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_s !== 16'd0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_after: cycle %0d out %0h busy %b expected 0 0", i, out_s, busy);
      end
    end
  endtask

  task automatic test_latency();
    logic [15:0] exp, exp_out;
    logic exp_busy;
    apply_reset();
    do_strobe(1000);
    exp = model_sample(1000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy0: got %b expected 1", busy); end
    checks++; if (out_s !== 16'd0) begin errors++; $display("FAIL latency_out0: got %0d expected 0", $signed(out_s)); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_out  = (i < 17) ? 16'd0 : exp;
      exp_busy = (i < 17);
      checks++;
      if (out_s !== exp_out) begin errors++; $display("FAIL latency_out: edge+%0d got %0d expected %0d", i, $signed(out_s), $signed(exp_out)); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL latency_busy: edge+%0d got %b expected %b", i, busy, exp_busy); end
    end
  endtask

  task automatic test_step();
    logic [15:0] exp;
    int n;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_strobe(0);
      exp = model_sample(0);
      wait_idle(n);
      checks++; if (n != 17) begin errors++; $display("FAIL step_zero_busy: got %0d cycles expected 17", n); end
      checks++; if (out_s !== exp) begin errors++; $display("FAIL step_zero_out: got %0d expected %0d", $signed(out_s), $signed(exp)); end
    end
    for (int i = 0; i < 1000; i++) begin
      do_strobe(10000);
      exp = model_sample(10000);
      wait_idle(n);
      checks++;
      if (out_s !== exp) begin errors++; $display("FAIL step_out: sample %0d got %0d expected %0d", i, $signed(out_s), $signed(exp)); end
      if (i == 0) begin
        checks++;
        if ($signed(out_s) < 9900 || $signed(out_s) > 10000) begin
          errors++; $display("FAIL step_first_range: got %0d expected 9900..10000", $signed(out_s));
        end
      end
    end
    checks++;
    if ($signed(out_s) > 2 || $signed(out_s) < 0) begin errors++; $display("FAIL step_settled: got %0d expected 0..2", $signed(out_s)); end
  endtask

  task automatic test_neg_saturation();
    logic [15:0] exp;
    int n;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_strobe(32767);
      exp = model_sample(32767);
      wait_idle(n);
      checks++; if (out_s !== exp) begin errors++; $display("FAIL negsat_hold: got %0d expected %0d", $signed(out_s), $signed(exp)); end
    end
    do_strobe(-32768);
    exp = model_sample(-32768);
    wait_idle(n);
    checks++; if (n != 17) begin errors++; $display("FAIL negsat_busy: got %0d cycles expected 17", n); end
    checks++; if (out_s !== 16'h8000) begin errors++; $display("FAIL negsat_clamp: got %0d expected -32768", $signed(out_s)); end
    checks++; if (out_s !== exp) begin errors++; $display("FAIL negsat_model: got %0d expected %0d", $signed(out_s), $signed(exp)); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp, exp_prev, exp_out;
    int gaps[3];
    int n, a, b;
    apply_reset();
    do_strobe(3000);
    exp = model_sample(3000);
    wait_idle(n);
    checks++; if (out_s !== exp) begin errors++; $display("FAIL overrun_prime: got %0d expected %0d", $signed(out_s), $signed(exp)); end
    gaps[0] = 4;
    gaps[1] = $urandom_range(1, 16);
    gaps[2] = $urandom_range(1, 16);
    for (int g = 0; g < 3; g++) begin
      a = $urandom_range(0, 40000) - 20000;
      b = $urandom_range(0, 40000) - 20000;
      exp_prev = m_out;
      do_strobe(a);
      model_abandon(a, gaps[g]);
      for (int i = 1; i < gaps[g]; i++) begin
        tick();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: gap %0d edge+%0d got %b expected 0", gaps[g], i, overrun); end
      end
      do_strobe(b);
      exp = model_sample(b);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: gap %0d got %b expected 1", gaps[g], overrun); end
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (i == 1) begin
          checks++;
          if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b expected 0", overrun); end
        end
        exp_out = (i < 17) ? exp_prev : exp;
        checks++;
        if (out_s !== exp_out) begin
          errors++; $display("FAIL overrun_out: gap %0d edge+%0d got %0d expected %0d", gaps[g], i, $signed(out_s), $signed(exp_out));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a, exp_b;
    int n, a, b;
    for (int p = 0; p < 3; p++) begin
      a = $urandom_range(0, 65535) - 32768;
      b = $urandom_range(0, 65535) - 32768;
      do_strobe(a);
      exp_a = model_sample(a);
      repeat (16) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_before: got %b expected 1", busy); end
      do_strobe(b);
      checks++; if (out_s !== exp_a) begin errors++; $display("FAIL b2b_out_a: got %0d expected %0d", $signed(out_s), $signed(exp_a)); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_after: got %b expected 1", busy); end
      exp_b = model_sample(b);
      wait_idle(n);
      checks++; if (n != 17) begin errors++; $display("FAIL b2b_busy_len: got %0d expected 17", n); end
      checks++; if (out_s !== exp_b) begin errors++; $display("FAIL b2b_out_b: got %0d expected %0d", $signed(out_s), $signed(exp_b)); end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    int n, v;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 65535) - 32768;
      do_strobe(v);
      exp = model_sample(v);
      wait_idle(n);
      checks++; if (n != 17) begin errors++; $display("FAIL random_busy: sample %0d got %0d expected 17", i, n); end
      checks++; if (out_s !== exp) begin errors++; $display("FAIL random_out: sample %0d in %0d got %0d expected %0d", i, v, $signed(out_s), $signed(exp)); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL random_overrun: sample %0d got %b expected 0", i, overrun); end
      repeat ($urandom_range(0, 5)) tick();
    end
  endtask

  task automatic test_dc_rejection();
    logic [15:0] exp;
    int n;
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      do_strobe(-5000);
      exp = model_sample(-5000);
      wait_idle(n);
      checks++;
      if (out_s !== exp) begin errors++; $display("FAIL dc_out: sample %0d got %0d expected %0d", i, $signed(out_s), $signed(exp)); end
      checks++;
      if ($signed(out_s) > 5000 || $signed(out_s) < -5000) begin
        errors++; $display("FAIL dc_bound: sample %0d got %0d expected within 5000", i, $signed(out_s));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    audio_clk_en = 1'b0;
    in_s = 16'd0;
    model_reset();
    test_reset();
    test_latency();
    test_step();
    test_neg_saturation();
    test_overrun();
    test_back_to_back();
    test_random();
    test_dc_rejection();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
